hsi2rgb_arbiter: RTL and testbench

Shares one combinational HSI-to-RGB converter between two HSI pixel streams: A is the live style-transfer path and B is the preview/overlay path. The block arbitrates round-robin with a configurable burst lock so each stream keeps line-contiguous runs. It drives the converter inputs from the granted stream and registers the converter result into a single output stage with a valid/ready handshake. It sits between the HSI processing stages and the RGB frame writer.

---
 rtl/hsi2rgb_arbiter_if.sv | 51 +++++
 rtl/hsi2rgb_arbiter.sv | 145 ++++++++++++++
 tb/tb_hsi2rgb_arbiter.sv | 340 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/hsi2rgb_arbiter_if.sv
// Pixel, converter and output handshake bundle for hsi2rgb_arbiter.
// The arbiter takes the slave modport; the surrounding streams, converter and writer take master.
interface hsi2rgb_arbiter_if;
  // Stream A (live style-transfer path)
  logic       iA_valid;
  logic       oA_ready;
  logic [8:0] iA_H;
  logic [7:0] iA_S;
  logic [7:0] iA_I;
  // Stream B (preview/overlay path)
  logic       iB_valid;
  logic       oB_ready;
  logic [8:0] iB_H;
  logic [7:0] iB_S;
  logic [7:0] iB_I;
  // Shared combinational converter
  logic [8:0] oCvt_H;
  logic [7:0] oCvt_S;
  logic [7:0] oCvt_I;
  logic [7:0] iCvt_R;
  logic [7:0] iCvt_G;
  logic [7:0] iCvt_B;
  // Registered RGB output towards the frame writer
  logic       oValid;
  logic       iReady;
  logic [7:0] oR;
  logic [7:0] oG;
  logic [7:0] oB;
  logic       oSrc;
  logic [1:0] oGrant;

  modport master (
    output iA_valid, iA_H, iA_S, iA_I,
    output iB_valid, iB_H, iB_S, iB_I,
    output iCvt_R, iCvt_G, iCvt_B,
    output iReady,
    input  oA_ready, oB_ready,
    input  oCvt_H, oCvt_S, oCvt_I,
    input  oValid, oR, oG, oB, oSrc, oGrant
  );

  modport slave (
    input  iA_valid, iA_H, iA_S, iA_I,
    input  iB_valid, iB_H, iB_S, iB_I,
    input  iCvt_R, iCvt_G, iCvt_B,
    input  iReady,
    output oA_ready, oB_ready,
    output oCvt_H, oCvt_S, oCvt_I,
    output oValid, oR, oG, oB, oSrc, oGrant
  );
endinterface

// File: rtl/hsi2rgb_arbiter.sv
// Round-robin, burst-locked arbiter sharing one HSI->RGB converter between streams A and B,
// with a registered valid/ready output stage. Define HSI_HUE_WRAP_EN to fold hues >= 360.
module hsi2rgb_arbiter #(
  parameter int unsigned BURST_LEN = 16
) (
  input logic              iCLK,
  input logic              iRST_N,
  hsi2rgb_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    GNT_A = 2'b01,
    GNT_B = 2'b10
  } state_e;

  localparam logic [7:0] BURST_MAX = 8'(BURST_LEN);

  state_e     state_q, state_d;
  state_e     other;
  logic       last_b_q, last_b_d;
  logic [7:0] burst_q, burst_d, burst_inc;

  logic       valid_q, src_q;
  logic [7:0] r_q, g_q, b_q;

  logic       stall, x_valid, y_valid, expired, hold_off;
  logic       a_ready, b_ready, accept;
  logic [8:0] hue_sel;
  logic [7:0] sat_sel, int_sel;

  assign stall     = valid_q && !bus.iReady;
  assign x_valid   = (state_q == GNT_B) ? bus.iB_valid : bus.iA_valid;
  assign y_valid   = (state_q == GNT_B) ? bus.iA_valid : bus.iB_valid;
  assign other     = (state_q == GNT_B) ? GNT_A : GNT_B;
  // A full burst with the other stream waiting holds off accepts: that cycle is the hand-over bubble.
  assign expired   = (burst_q == BURST_MAX);
  assign hold_off  = expired && y_valid;
  assign burst_inc = expired ? 8'd1 : burst_q + 8'd1;
  assign accept    = (a_ready && bus.iA_valid) || (b_ready && bus.iB_valid);

  // State register
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      state_q  <= IDLE;
      // Last grant starts as B so that A wins the first simultaneous request.
      last_b_q <= 1'b1;
      burst_q  <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
      state_q  <= state_d;
      last_b_q <= last_b_d;
      burst_q  <= burst_d;
    end
  end

  // Next-state, last-grant and burst counter
  always_comb begin
    // NOTE: every combinational output gets a default first, so no path can infer a latch.
    state_d  = state_q;
    last_b_d = last_b_q;
    burst_d  = burst_q;
    case (state_q)
      IDLE: begin
        if (bus.iA_valid && bus.iB_valid) state_d = last_b_q ? GNT_A : GNT_B;
        else if (bus.iA_valid)            state_d = GNT_A;
        else if (bus.iB_valid)            state_d = GNT_B;
      end
      GNT_A, GNT_B: begin
        if (!x_valid)                state_d = y_valid ? other : IDLE;
        else if (hold_off && !stall) state_d = other;
        last_b_d = (state_q == GNT_B);
      end
      default: state_d = IDLE;
    endcase
    if (state_d != state_q) begin
      burst_d = '0;
    end else if (accept) begin
      // Burst reached with nobody waiting: restart the count and keep the grant.
      burst_d = (burst_inc == BURST_MAX && !y_valid) ? '0 : burst_inc;
    end
  end

  // Output decode: readies and converter drive
  always_comb begin
    a_ready = 1'b0;
    b_ready = 1'b0;
    hue_sel = '0;
    sat_sel = '0;
    int_sel = '0;
    case (state_q)
      GNT_A: begin
        a_ready = !stall && !hold_off;
        hue_sel = bus.iA_H;
        sat_sel = bus.iA_S;
        int_sel = bus.iA_I;
      end
      GNT_B: begin
        b_ready = !stall && !hold_off;
        hue_sel = bus.iB_H;
        sat_sel = bus.iB_S;
        int_sel = bus.iB_I;
      end
      default: ;
    endcase
  end

`ifdef HSI_HUE_WRAP_EN
  assign bus.oCvt_H = (hue_sel >= 9'd360) ? hue_sel - 9'd360 : hue_sel;
`else
  assign bus.oCvt_H = hue_sel;
`endif
  assign bus.oCvt_S   = sat_sel;
  assign bus.oCvt_I   = int_sel;
  assign bus.oA_ready = a_ready;
  assign bus.oB_ready = b_ready;
  assign bus.oGrant   = state_q;

  // Output pixel register
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      // NOTE: the pixel data is reset as well, so a held pixel cannot reappear after reset release.
      valid_q <= 1'b0;
      src_q   <= 1'b0;
      r_q     <= '0;
      g_q     <= '0;
      b_q     <= '0;
    end else if (accept) begin
      valid_q <= 1'b1;
      src_q   <= (state_q == GNT_B);
      r_q     <= bus.iCvt_R;
      g_q     <= bus.iCvt_G;
      b_q     <= bus.iCvt_B;
    end else if (bus.iReady) begin
      valid_q <= 1'b0;
    end
  end

  assign bus.oValid = valid_q;
  assign bus.oSrc   = src_q;
  assign bus.oR     = r_q;
  assign bus.oG     = g_q;
  assign bus.oB     = b_q;

endmodule

// File: tb/tb_hsi2rgb_arbiter.sv
// Scoreboard bench for hsi2rgb_arbiter: per-stream expected queues filled when pixels are
// issued, drained by an output monitor; directed phases cover latency, bursts, stall, reset, hue wrap.
module tb_hsi2rgb_arbiter;

  localparam int BL = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  hsi2rgb_arbiter_if bus ();

  hsi2rgb_arbiter #(.BURST_LEN(BL)) dut (
    .iCLK  (clk),
    .iRST_N(rst_n),
    .bus   (bus)
  );

  // Stand-in converter: gray when saturation is zero, hue-dependent otherwise.
  function automatic logic [23:0] cvt(input logic [8:0] h, input logic [7:0] s, input logic [7:0] i);
    return {i, i ^ s, i ^ (s & h[7:0])};
  endfunction

  function automatic logic [23:0] exp_rgb(input logic [8:0] h, input logic [7:0] s, input logic [7:0] i);
    logic [8:0] he;
    he = h;
`ifdef HSI_HUE_WRAP_EN
    if (h >= 9'd360) he = h - 9'd360;
`endif
    return cvt(he, s, i);
  endfunction

  always_comb {bus.iCvt_R, bus.iCvt_G, bus.iCvt_B} = cvt(bus.oCvt_H, bus.oCvt_S, bus.oCvt_I);

  // Stimulus state: main sets mode/target/fixed pixel, the driver owns vld/issued/pixel regs.
  int         mode[2]   = '{0, 0};   // 0 off, 1 continuous, 2 random gaps
  int         target[2] = '{0, 0};
  int         issued[2] = '{0, 0};
  bit         use_fix[2] = '{0, 0};
  logic [8:0] fh[2];
  logic [7:0] fs[2], fi[2];
  logic       vld[2] = '{1'b0, 1'b0};
  logic [8:0] ph[2] = '{9'd0, 9'd0};
  logic [7:0] ps[2] = '{8'd0, 8'd0};
  logic [7:0] pi[2] = '{8'd0, 8'd0};
  logic       fire[2] = '{1'b0, 1'b0};
  int         ready_mode = 1;        // 0 low, 1 high, 2 random
  logic       rdy = 1'b0;

  logic [23:0] exp_a[$];
  logic [23:0] exp_b[$];
  int          acc_a[$];
  int          out_src[$];
  int          out_cyc[$];

  int errors = 0;
  int checks = 0;

  assign bus.iA_valid = vld[0];
  assign bus.iA_H     = ph[0];
  assign bus.iA_S     = ps[0];
  assign bus.iA_I     = pi[0];
  assign bus.iB_valid = vld[1];
  assign bus.iB_H     = ph[1];
  assign bus.iB_S     = ps[1];
  assign bus.iB_I     = pi[1];
  assign bus.iReady   = rdy;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // Handshake sampler: a pixel valid and ready at the falling edge is taken at the next rising edge.
  always @(negedge clk) begin
    fire[0] = rst_n && vld[0] && bus.oA_ready;
    fire[1] = rst_n && vld[1] && bus.oB_ready;
    if (fire[0]) acc_a.push_back(cyc);
  end

  // Driver: updates inputs just after each rising edge.
  initial forever begin
    @(posedge clk);
    #1;
    for (int s = 0; s < 2; s++) begin
      if (!rst_n) begin
        vld[s] = 1'b0;
      end else begin
        if (fire[s]) vld[s] = 1'b0;
        if (!vld[s] && mode[s] != 0 && issued[s] < target[s] &&
            (mode[s] == 1 || $urandom_range(1, 0) == 1)) begin
          ph[s] = use_fix[s] ? fh[s] : 9'($urandom_range(511, 0));
          ps[s] = use_fix[s] ? fs[s] : 8'($urandom_range(255, 0));
          pi[s] = use_fix[s] ? fi[s] : 8'($urandom_range(255, 0));
          vld[s] = 1'b1;
          issued[s]++;
          if (s == 0) exp_a.push_back(exp_rgb(ph[s], ps[s], pi[s]));
          else        exp_b.push_back(exp_rgb(ph[s], ps[s], pi[s]));
        end
      end
    end
    rdy = (ready_mode == 1) ? 1'b1 : (ready_mode == 2) ? 1'($urandom_range(1, 0)) : 1'b0;
  end

  // Monitor: pops the scoreboard on every output handshake and watches stall behaviour.
  logic        prev_hold = 1'b0;
  logic [24:0] prev_px   = '0;
  always @(negedge clk) begin
    logic [23:0] expd;
    if (!rst_n) begin
      exp_a.delete();
      exp_b.delete();
      prev_hold = 1'b0;
    end else begin
      if (prev_hold)
        check("hold_stable", {bus.oValid, bus.oSrc, bus.oR, bus.oG, bus.oB}, {1'b1, prev_px});
      if (bus.oValid && !rdy)
        check("stall_ready", {bus.oA_ready, bus.oB_ready}, 2'b00);
      if (bus.oValid && rdy) begin
        if ((bus.oSrc == 1'b0 && exp_a.size() == 0) || (bus.oSrc == 1'b1 && exp_b.size() == 0)) begin
          checks++;
          errors++;
          $display("FAIL unexpected_pixel: src=%0d rgb=%h with no pending pixel for that stream",
                   bus.oSrc, {bus.oR, bus.oG, bus.oB});
        end else begin
          expd = (bus.oSrc == 1'b0) ? exp_a.pop_front() : exp_b.pop_front();
          check(bus.oSrc ? "pixel_b" : "pixel_a", {bus.oR, bus.oG, bus.oB}, expd);
        end
        out_src.push_back(int'(bus.oSrc));
        out_cyc.push_back(cyc);
      end
      prev_hold = bus.oValid && !rdy;
      prev_px   = {bus.oSrc, bus.oR, bus.oG, bus.oB};
    end
  end

  function automatic bit idle();
    return issued[0] == target[0] && issued[1] == target[1] && !vld[0] && !vld[1] &&
           exp_a.size() == 0 && exp_b.size() == 0 && !bus.oValid;
  endfunction

  task automatic wait_idle(input string name, input int budget);
    int n = 0;
    while (!idle() && n < budget) begin
      tick();
      n++;
    end
    check(name, idle(), 1);
    tick();
  endtask

  task automatic set_fix(input int s, input logic [8:0] h, input logic [7:0] sv, input logic [7:0] iv);
    use_fix[s] = 1'b1;
    fh[s] = h;
    fs[s] = sv;
    fi[s] = iv;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin
    int base, abase, n, ok, b;
    logic [23:0] held;
    logic [8:0]  exp_h;

    // Reset values
    repeat (3) tick();
    check("reset_state", {bus.oValid, bus.oA_ready, bus.oB_ready, bus.oGrant, bus.oSrc,
                          bus.oR, bus.oG, bus.oB}, '0);
    check("reset_cvt", {bus.oCvt_H, bus.oCvt_S, bus.oCvt_I}, '0);
    rst_n = 1'b1;
    tick();

    // Single stream A, gray pixels, no bubbles
    base  = out_src.size();
    abase = acc_a.size();
    set_fix(0, 9'd0, 8'd0, 8'd128);
    mode[0] = 1;
    target[0] += 20;
    wait_idle("p1_drain", 500);
    check("p1_count", out_src.size() - base, 20);
    if (out_src.size() - base >= 20 && acc_a.size() > abase) begin
      check("p1_latency", out_cyc[base], acc_a[abase] + 1);
      check("p1_no_bubble", out_cyc[base+19] - out_cyc[base], 19);
      n = 0;
      for (int i = 0; i < 20; i++) n += out_src[base+i];
      check("p1_src_a", n, 0);
    end
    use_fix[0] = 1'b0;
    mode[0] = 0;

    // Both streams continuous: runs of BL with one bubble between
    base = out_src.size();
    mode[0] = 1;
    mode[1] = 1;
    target[0] += 24;
    target[1] += 24;
    wait_idle("p2_drain", 1000);
    check("p2_count", out_src.size() - base, 48);
    if (out_src.size() - base >= 4 * BL) begin
      for (int k = 0; k < 4; k++) begin
        b  = base + k * BL;
        ok = 1;
        for (int j = 1; j < BL; j++)
          if (out_src[b+j] != out_src[b] || out_cyc[b+j] != out_cyc[b] + j) ok = 0;
        if (k > 0 && (out_src[b] == out_src[b-1] || out_cyc[b] != out_cyc[b-1] + 2)) ok = 0;
        check($sformatf("p2_run%0d", k), ok, 1);
      end
    end
    mode[0] = 0;
    mode[1] = 0;

    // Downstream stall on stream A
    base = out_src.size();
    mode[0] = 1;
    target[0] += 10;
    n = 0;
    while (!bus.oValid && n < 50) begin
      tick();
      n++;
    end
    check("p3_first_valid", bus.oValid, 1);
    ready_mode = 0;
    tick();
    held = {bus.oR, bus.oG, bus.oB};
    for (int k = 0; k < 5; k++) begin
      tick();
      check("p3_stall_ready", bus.oA_ready, 0);
      check("p3_stall_rgb", {bus.oR, bus.oG, bus.oB}, held);
    end
    ready_mode = 1;
    tick();
    check("p3_resume", bus.oA_ready, 1);
    wait_idle("p3_drain", 200);
    check("p3_count", out_src.size() - base, 10);
    mode[0] = 0;

    // A drops after 2 pixels while B waits
    mode[0] = 1;
    target[0] += 2;
    tick();
    mode[1] = 1;
    target[1] += 4;
    n = 0;
    while (!(issued[0] == target[0] && !vld[0]) && n < 50) begin
      tick();
      n++;
    end
    check("p4_still_a", bus.oGrant, 2'b01);
    tick();
    check("p4_grant_b", bus.oGrant, 2'b10);
    check("p4_counter", dut.burst_q, 0);
    wait_idle("p4_drain", 200);
    mode[0] = 0;
    mode[1] = 0;

    // Asynchronous reset while B holds a stalled pixel
    mode[1] = 1;
    target[1] += 3;
    ready_mode = 0;
    n = 0;
    while (!(bus.oValid && bus.oGrant == 2'b10) && n < 50) begin
      tick();
      n++;
    end
    check("p5_setup", {bus.oValid, bus.oGrant}, 3'b110);
    #1 rst_n = 1'b0;
    #1;
    check("p5_async_reset", {bus.oValid, bus.oA_ready, bus.oB_ready, bus.oGrant, bus.oSrc,
                             bus.oR, bus.oG, bus.oB}, '0);
    mode[1] = 0;
    target[1] = issued[1];
    ready_mode = 1;
    tick();
    tick();
    rst_n = 1'b1;
    base = out_src.size();
    mode[0] = 1;
    mode[1] = 1;
    target[0] += 4;
    target[1] += 4;
    wait_idle("p5_drain", 200);
    check("p5_count", out_src.size() - base, 8);
    if (out_src.size() > base) check("p5_first_a", out_src[base], 0);
    mode[0] = 0;
    mode[1] = 0;

    // Hue above 359 on the converter drive
    set_fix(0, 9'd480, 8'd255, 8'd255);
    mode[0] = 1;
    target[0] += 1;
    n = 0;
    while (!(bus.oGrant == 2'b01 && bus.iA_valid) && n < 20) begin
      tick();
      n++;
    end
`ifdef HSI_HUE_WRAP_EN
    exp_h = 9'd120;
`else
    exp_h = 9'd480;
`endif
    check("p6_cvt_hsi", {bus.oCvt_H, bus.oCvt_S, bus.oCvt_I}, {exp_h, 8'd255, 8'd255});
    wait_idle("p6_drain", 100);
    use_fix[0] = 1'b0;
    mode[0] = 0;
    check("p6_idle_cvt", {bus.oGrant, bus.oCvt_H, bus.oCvt_S, bus.oCvt_I}, '0);

    // Random traffic on both streams with random back-pressure
    base = out_src.size();
    mode[0] = 2;
    mode[1] = 2;
    target[0] += 150;
    target[1] += 150;
    ready_mode = 2;
    wait_idle("p7_drain", 5000);
    check("p7_count", out_src.size() - base, 300);
    ready_mode = 1;
    mode[0] = 0;
    mode[1] = 0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
